// File: rtl/regfile_writer.sv
// regfile_writer: in-order result FIFO feeding register-file writes with x86-64 partial-register merge.
// Define REGFILE_WRITER_PENDING_EN to enable per-register outstanding-write tracking on pending.
module regfile_writer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_reg,
  input  logic [2:0]       in_size,
  input  logic [63:0]      in_data,
  output logic [IDX_W-1:0] rf_rd_idx,
  input  logic [63:0]      rf_rd_data,
  output logic             rf_wr_en,
  output logic [IDX_W-1:0] rf_wr_idx,
  output logic [63:0]      rf_wr_data,
  output logic             busy,
  output logic [15:0]      pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, MERGE, WRITE} stateT;
  stateT state, nextState;
  logic [IDX_W-1:0] fifoReg [DEPTH];
  logic [2:0] fifoSize [DEPTH];
  logic [63:0] fifoData [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [2:0] entSize;
  logic [15:0] entData;
  logic push, pop;
  logic [IDX_W-1:0] headReg;
  logic [2:0] headSize;
  logic [63:0] headData, headWide, merged;
  always_comb begin
    in_ready = !reset && count != FULL;
    push = in_valid && in_ready;
    pop = state != MERGE && count != '0;
    headReg = fifoReg[rdPtr];
    headData = fifoData[rdPtr];
    headSize = fifoSize[rdPtr] > 3'd4 ? 3'd4 : fifoSize[rdPtr];
    headWide = headSize == 3'd4 ? headData : {32'b0, headData[31:0]};
    merged = entSize == 3'd0 ? {rf_rd_data[63:8], entData[7:0]} :
             entSize == 3'd1 ? {rf_rd_data[63:16], entData[7:0], rf_rd_data[7:0]} :
                               {rf_rd_data[63:16], entData};
    nextState = state == MERGE ? WRITE : !pop ? IDLE : headSize >= 3'd3 ? WRITE : MERGE;
    busy = count != '0 || state != IDLE;
  end
  // rf_rd_idx doubles as the entry register so MERGE reads the popped target directly
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      rf_rd_idx <= '0;
      entSize <= '0;
      entData <= '0;
      rf_wr_en <= 1'b0;
      rf_wr_idx <= '0;
      rf_wr_data <= '0;
    end else begin
      state <= nextState;
      count <= count + CW'(push) - CW'(pop);
      rf_wr_en <= nextState == WRITE;
      if (push) begin
        fifoReg[wrPtr] <= in_reg;
        fifoSize[wrPtr] <= in_size;
        fifoData[wrPtr] <= in_data;
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
        rf_rd_idx <= headReg;
        entSize <= headSize;
        entData <= headData[15:0];
      end
      if (state == MERGE) begin
        rf_wr_idx <= rf_rd_idx;
        rf_wr_data <= merged;
      end else if (pop && headSize >= 3'd3) begin
        rf_wr_idx <= headReg;
        rf_wr_data <= headWide;
      end
    end
  end
`ifdef REGFILE_WRITER_PENDING_EN
  localparam int NW = $clog2(DEPTH + 2);
  logic [NW-1:0] pendCnt [16];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (reset) pendCnt[i] <= '0;
      else pendCnt[i] <= pendCnt[i] + NW'(push && in_reg == IDX_W'(i)) - NW'(rf_wr_en && rf_wr_idx == IDX_W'(i));
    end
  end
  always_comb begin
    pending = '0;
    for (int i = 0; i < 16; i++) pending[i] = pendCnt[i] != '0;
  end
`else
  assign pending = '0;
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: table vectors, corner sequences and random traffic against a behavioural register-file model.
module tb_regfile_writer;
`ifdef REGFILE_WRITER_PENDING_EN
  localparam logic PEND_ON = 1'b1;
`else
  localparam logic PEND_ON = 1'b0;
`endif
  typedef struct {logic [3:0] idx; logic [63:0] val;} wrT;
  typedef struct {logic [3:0] r; logic [2:0] s; logic [63:0] d; logic [63:0] pre; logic [63:0] exp; int lat;} vecT;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [3:0] in_reg = '0;
  logic [2:0] in_size = '0;
  logic [63:0] in_data = '0;
  logic [3:0] rf_rd_idx;
  logic [63:0] rf_rd_data;
  logic rf_wr_en;
  logic [3:0] rf_wr_idx;
  logic [63:0] rf_wr_data;
  logic busy;
  logic [15:0] pending;
  logic [63:0] rf [16] = '{default: '0};
  logic [63:0] modelRf [16] = '{default: '0};
  logic pokeEn = 0;
  logic [3:0] pokeIdx = '0;
  logic [63:0] pokeVal = '0;
  logic pokeDone = 0;
  logic [3:0] pokeIdxQ = '0;
  logic [63:0] pokeValQ = '0;
  logic accValid = 0;
  logic [3:0] accReg = '0;
  logic [2:0] accSize = '0;
  logic [63:0] accData = '0;
  wrT expQ [$];
  int outst [16];
  int compared = 0;
  int mismatched = 0;
  int wrCount = 0;
  logic sawStall = 0;
  vecT vecs [10];

  regfile_writer #(.DEPTH(4), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_size(in_size), .in_data(in_data),
    .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;
  assign rf_rd_data = rf[rf_rd_idx];

  // Register file storage plus a one-cycle record of accepts/pokes for the model
  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_idx] <= rf_wr_data;
    else if (pokeEn) rf[pokeIdx] <= pokeVal;
    pokeDone <= pokeEn && !rf_wr_en;
    pokeIdxQ <= pokeIdx;
    pokeValQ <= pokeVal;
    accValid <= in_valid && in_ready;
    accReg <= in_reg;
    accSize <= in_size;
    accData <= in_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] applyWrite(input logic [63:0] old, input logic [2:0] s, input logic [63:0] d);
    logic [63:0] mask;
    int sh;
    if (s == 3'd3) return d & 64'h0000_0000_FFFF_FFFF;
    if (s > 3'd3) return d;
    mask = s == 3'd2 ? 64'hFFFF : 64'hFF;
    sh = s == 3'd1 ? 8 : 0;
    return (old & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  task automatic monitor();
    wrT e;
    logic [63:0] nv;
    logic [15:0] expP;
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
        for (int i = 0; i < 16; i++) begin
          outst[i] = 0;
          modelRf[i] = rf[i];
        end
      end else begin
        if (pokeDone) modelRf[pokeIdxQ] = pokeValQ;
        if (accValid) begin
          nv = applyWrite(modelRf[accReg], accSize, accData);
          modelRf[accReg] = nv;
          expQ.push_back('{accReg, nv});
          outst[accReg]++;
        end
        for (int i = 0; i < 16; i++) expP[i] = PEND_ON && outst[i] != 0;
        chk("pending_mask", pending, expP);
        if (rf_wr_en) begin
          wrCount++;
          if (expQ.size() == 0) chk("spurious_write", rf_wr_en, 0);
          else begin
            e = expQ.pop_front();
            chk("wr_idx", rf_wr_idx, e.idx);
            chk("wr_data", rf_wr_data, e.val);
            outst[e.idx]--;
          end
        end
      end
    end
  endtask

  task automatic poke(input logic [3:0] r, input logic [63:0] v);
    pokeEn = 1;
    pokeIdx = r;
    pokeVal = v;
    @(negedge clk);
    pokeEn = 0;
  endtask

  task automatic send(input logic [3:0] r, input logic [2:0] s, input logic [63:0] d);
    int n = 0;
    in_valid = 1;
    in_reg = r;
    in_size = s;
    in_data = d;
    if (!in_ready) sawStall = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_queue", expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int c1, c2, nw, sawWr;
    logic [63:0] got [2];
    vecs[0] = '{4'd0, 3'd4, 64'h1122334455667788, 64'h0, 64'h1122334455667788, 2};
    vecs[1] = '{4'd0, 3'd1, 64'h00000000000000AB, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFABFF, 3};
    vecs[2] = '{4'd0, 3'd3, 64'hDEADBEEF12345678, 64'hFFFFFFFFFFFFABFF, 64'h0000000012345678, 2};
    vecs[3] = '{4'd3, 3'd0, 64'hF00000000000CD01, 64'h0, 64'h0000000000000001, 3};
    vecs[4] = '{4'd5, 3'd2, 64'hAAAAAAAAAAAACAFE, 64'h1111111111111111, 64'h111111111111CAFE, 3};
    vecs[5] = '{4'd7, 3'd7, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF, 2};
    vecs[6] = '{4'd15, 3'd0, 64'h000000000000005A, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFF5A, 3};
    vecs[7] = '{4'd2, 3'd1, 64'h00000000000012C3, 64'h0, 64'h000000000000C300, 3};
    vecs[8] = '{4'd4, 3'd5, 64'h8000000000000001, 64'h1234, 64'h8000000000000001, 2};
    vecs[9] = '{4'd8, 3'd3, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h0000000080000000, 2};
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_wr_idx", rf_wr_idx, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_rd_idx", rf_rd_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      poke(vecs[i].r, vecs[i].pre);
      in_valid = 1;
      in_reg = vecs[i].r;
      in_size = vecs[i].s;
      in_data = vecs[i].d;
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("v%0d_early", i), rf_wr_en, 0);
      for (int c = 1; c < vecs[i].lat; c++) begin
        @(negedge clk);
        if (c < vecs[i].lat - 1) begin
          chk($sformatf("v%0d_merge_idx", i), rf_rd_idx, vecs[i].r);
          chk($sformatf("v%0d_merge_en", i), rf_wr_en, 0);
        end
      end
      chk($sformatf("v%0d_en", i), rf_wr_en, 1);
      chk($sformatf("v%0d_idx", i), rf_wr_idx, vecs[i].r);
      chk($sformatf("v%0d_data", i), rf_wr_data, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("v%0d_single", i), rf_wr_en, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    // Back-to-back byte merges to RBX: second merge must see the first write
    poke(4'd3, 64'h0);
    send(4'd3, 3'd0, 64'h01);
    send(4'd3, 3'd0, 64'h02);
    nw = 0;
    c1 = 0;
    c2 = 0;
    got[0] = '1;
    got[1] = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rf_wr_en && nw < 2) begin
        got[nw] = rf_wr_data;
        if (nw == 0) c1 = c;
        else c2 = c;
        nw++;
      end
    end
    chk("raw_first", got[0], 64'h01);
    chk("raw_second", got[1], 64'h02);
    chk("raw_gap", c2 - c1, 2);
    drain();
    // Stream of 16-bit merges outruns the writer until the FIFO fills
    base = wrCount;
    sawStall = 0;
    for (int i = 0; i < 12; i++) send(4'(8 + i % 8), 3'd2, 64'(i * 32'h1111 + 1));
    drain();
    chk("stream_writes", wrCount - base, 12);
    chk("stream_stall", sawStall, 1);
    // Reset while MERGE is active with two entries queued
    for (int i = 0; i < 4; i++) send(4'd6, 3'd0, 64'(8'h10 + i));
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_merge", rf_wr_en, 0);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_wr_en", rf_wr_en, 0);
    chk("mid_rst_wr_idx", rf_wr_idx, 0);
    chk("mid_rst_wr_data", rf_wr_data, 0);
    chk("mid_rst_rd_idx", rf_rd_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ready", in_ready, 0);
    reset = 0;
    @(negedge clk);
    chk("after_rst_ready", in_ready, 1);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_pending", pending, 0);
    sawWr = 0;
    repeat (5) begin
      @(negedge clk);
      if (rf_wr_en) sawWr = 1;
    end
    chk("after_rst_no_write", sawWr, 0);
    // Three writes to R9: pending[9] holds through the third write cycle
    send(4'd9, 3'd4, 64'hA);
    send(4'd9, 3'd4, 64'hB);
    send(4'd9, 3'd4, 64'hC);
    @(negedge clk);
    chk("r9_third_en", rf_wr_en, 1);
    chk("r9_third_data", rf_wr_data, 64'hC);
    chk("r9_pend_last", pending[9], PEND_ON);
    @(negedge clk);
    chk("r9_pend_clear", pending[9], 0);
    chk("r9_no_repeat", rf_wr_en, 0);
    drain();
    // Randomized traffic with idle gaps
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Write-side front end for the 16-entry x 64-bit architectural register file.
- Accepts completed results from execute/commit via a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues exactly one register-file write per result.
- Applies x86-64 partial-register rules: 8-bit low, 8-bit high (AH/BH/CH/DH), 16-bit merge, 32-bit zero-extend, 64-bit full. Merges use a read-modify-write against the register file.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- IDX_W, 4, register index width (16 regs; RAX=0, RCX=1, RDX=2, RBX=3, RSP=4, RBP=5, RSI=6, RDI=7, R8..R15=8..15)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  result offered
- in_ready  out  1  FIFO can accept (not full, not in reset)
- in_reg  in  IDX_W  destination register
- in_size  in  3  0=low8, 1=high8 (bits 15:8), 2=16, 3=32, 4=64; 5-7 reserved
- in_data  in  64  result; low bits significant per in_size
- rf_rd_idx  out  IDX_W  merge read index
- rf_rd_data  in  64  combinational read data for rf_rd_idx
- rf_wr_en  out  1  write strobe, one cycle per write
- rf_wr_idx  out  IDX_W  write index
- rf_wr_data  out  64  write value
- busy  out  1  FIFO non-empty or FSM not IDLE
- pending  out  16  per-register outstanding-write mask (see Optional Feature)

Behaviour:
- Register file contract: rf_rd_data is combinational from rf_rd_idx. A write with rf_wr_en at posedge is visible on the read port the following cycle.
- Accept: in_valid && in_ready at posedge pushes {in_reg, in_size, in_data}.
- Reserved in_size codes are treated as 64.
- Pop of the head entry occurs only in IDLE or WRITE (see FSM).
- FSM states: IDLE, MERGE, WRITE.
- IDLE:
  - FIFO empty -> stay IDLE.
  - FIFO non-empty -> pop head into the entry register.
  - Size 3 or 4 -> WRITE, with wr value = size 4 ? data : {32'b0, data[31:0]}.
  - Size 0/1/2 -> MERGE.
- MERGE (1 cycle):
  - rf_rd_idx = entry.reg.
  - Merged value = rf_rd_data with the target field replaced: [7:0], [15:8] (from data[7:0]), or [15:0].
  - Latch the merged value -> WRITE.
- WRITE (1 cycle):
  - rf_wr_en=1, rf_wr_idx/rf_wr_data from the latched entry.
  - If FIFO non-empty, pop the next head in the same cycle and branch as in IDLE; else -> IDLE.
- Latency, from accept into an empty block to rf_wr_en:
  - 2 cycles for 32/64-bit (accept, pop, WRITE).
  - 3 cycles for 8/16-bit.
- Throughput: 1 write/cycle for 32/64 streams; 1 write per 2 cycles for partial writes.
- RAW between queued writes: a MERGE always follows the preceding entry's WRITE edge, so it reads the updated value. No bypass is required.
- Simultaneous push and pop when full: in_ready is computed from the current count and does not anticipate the pop, so no push occurs when full.
- Pointers wrap modulo DEPTH. Count is tracked explicitly, DEPTH+1 states.
- Reset:
  - Flushes the FIFO and returns the FSM to IDLE.
  - Outputs after the reset edge: rf_wr_en=0, rf_wr_idx=0, rf_wr_data=0, rf_rd_idx=0, busy=0, pending=0.
  - in_ready=0 while reset is high, and 1 in the first cycle after deassertion.
  - A write in flight when reset asserts is dropped; no rf_wr_en is asserted in the cycle after the reset edge.
- rf_wr_en is registered and never high for two consecutive cycles to the same entry.

Optional Feature:
- Macro: REGFILE_WRITER_PENDING_EN.
- Defined:
  - pending[r]=1 while any FIFO entry or the FSM entry targets register r.
  - Implemented with per-register outstanding counters, width clog2(DEPTH+2).
  - Increment on accept, decrement on the rf_wr_en cycle; simultaneous inc/dec of the same register leaves the count unchanged.
  - Cleared by reset.
- Undefined: the pending port is tied to 16'b0 and the counters are not instantiated.

Test Plan:
- Reset, then accept {reg=0, size=4, data=64'h1122334455667788} -> rf_wr_en 2 cycles after accept, idx=0, data=64'h1122334455667788; busy falls after.
- RAX=64'hFFFFFFFFFFFFFFFF, then {reg=0, size=1, data=8'hAB} -> MERGE reads idx 0; write 64'hFFFFFFFFFFFFABFF. Follow with {reg=0, size=3, data=32'h12345678} -> 64'h0000000012345678.
- Back-to-back: {3,size0,8'h01} then {3,size0,8'h02} with RBX=0 -> writes 64'h01 then 64'h02. The second merge reads the first's result.
- Hold rf side idle via a full stream of DEPTH+2 pushes of size 2 -> in_ready low at count=DEPTH. All DEPTH+2 writes emerge in order with no loss or duplication.
- Assert reset during a MERGE with 2 entries queued -> no rf_wr_en in the following cycles; busy=0 and in_ready=1 after deassert; pending=0.
- With REGFILE_WRITER_PENDING_EN: push three writes to R9 -> pending[9]=1 until the third rf_wr_en cycle, then 0. Without the macro, pending stays 0 throughout.
